// File: rtl/mem_arbiter.sv
// Memory-side arbiter: serves data-cache and instruction-cache requests on one RAM port,
// data first, with one-cycle wait release and per-source completion counters.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready,
    output logic [CNT_W-1:0]  icount,
    output logic [CNT_W-1:0]  dcount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  store_q, store_d;
    logic               wr_q, wr_d;
    logic [CNT_W-1:0]   icount_q, icount_d;
    logic [CNT_W-1:0]   dcount_q, dcount_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
            icount_q <= '0;
            dcount_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            wr_q     <= wr_d;
            icount_q <= icount_d;
            dcount_q <= dcount_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        store_d  = store_q;
        wr_d     = wr_q;
        icount_d = icount_q;
        dcount_d = dcount_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dREN || dWEN) begin
                    state_d = D_ACC;
                    addr_d  = daddr;
                    store_d = dstore;
                    wr_d    = dWEN;
                end else if (iREN) begin
                    state_d = I_ACC;
                    addr_d  = iaddr;
                    store_d = dstore;
                    wr_d    = 1'b0;
                end
            end
            D_ACC: begin
                // A dropped request aborts immediately: strobes never reach the RAM this cycle.
                if (!(dREN || dWEN)) begin
                    state_d = IDLE;
                end else begin
                    ramREN = !wr_q;
                    ramWEN = wr_q;
                    if (ram_ready) begin
                        dwait    = 1'b0;
                        dload    = ramload;
                        dcount_d = dcount_q + 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            I_ACC: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (ram_ready) begin
                        iwait    = 1'b0;
                        iload    = ramload;
                        icount_d = icount_q + 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign icount   = icount_q;
    assign dcount   = dcount_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter plus a narrow-counter wrap sequence.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, iren, dren, dwen, rdy;
    logic [31:0] iaddr, daddr, dstore, rload;
    logic        iwait, dwait, ramren, ramwen;
    logic [31:0] iload, dload, ramaddr, ramstore, icount, dcount;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) dut (
        .CLK(clk), .RST(rst),
        .iREN(iren), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dren), .dWEN(dwen), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramren), .ramWEN(ramwen), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(rload), .ram_ready(rdy),
        .icount(icount), .dcount(dcount)
    );

    // Second instance with 2-bit counters to exercise wraparound.
    logic        s_rst, s_dren, s_rdy;
    logic        s_iwait, s_dwait, s_ramren, s_ramwen;
    logic [31:0] s_iload, s_dload, s_ramaddr, s_ramstore;
    logic [1:0]  s_icount, s_dcount;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(2)) dut_w (
        .CLK(clk), .RST(s_rst),
        .iREN(1'b0), .iaddr(32'h0), .iwait(s_iwait), .iload(s_iload),
        .dREN(s_dren), .dWEN(1'b0), .daddr(32'h10), .dstore(32'h0),
        .dwait(s_dwait), .dload(s_dload),
        .ramREN(s_ramren), .ramWEN(s_ramwen), .ramaddr(s_ramaddr), .ramstore(s_ramstore),
        .ramload(32'h0000_00A5), .ram_ready(s_rdy),
        .icount(s_icount), .dcount(s_dcount)
    );

    typedef struct {
        logic        chk;
        logic        rst, iren, dren, dwen, rdy;
        logic [31:0] iaddr, daddr, dstore, rload;
        logic        e_iw, e_dw, e_rr, e_rw;
        logic [31:0] e_ra, e_rs, e_il, e_dl, e_ic, e_dc;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(
        input logic c, input logic r, input logic ir, input logic dr, input logic dw,
        input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
        input logic [31:0] rl, input logic rd,
        input logic iw, input logic dwt, input logic rr, input logic rw,
        input logic [31:0] ra, input logic [31:0] rs, input logic [31:0] il,
        input logic [31:0] dl, input logic [31:0] ic, input logic [31:0] dc);
        vec_t v;
        v.chk = c; v.rst = r; v.iren = ir; v.dren = dr; v.dwen = dw;
        v.iaddr = ia; v.daddr = da; v.dstore = ds; v.rload = rl; v.rdy = rd;
        v.e_iw = iw; v.e_dw = dwt; v.e_rr = rr; v.e_rw = rw;
        v.e_ra = ra; v.e_rs = rs; v.e_il = il; v.e_dl = dl; v.e_ic = ic; v.e_dc = dc;
        return v;
    endfunction

    task automatic check(input string nm, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_cnt[5];
        bit         done;

        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd0; exp_cnt[4] = 2'd1;

        rst = 1'b1; iren = 1'b0; dren = 1'b0; dwen = 1'b0; rdy = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; rload = '0;
        s_rst = 1'b1; s_dren = 1'b0; s_rdy = 1'b0;

        //            c r i d w  iaddr  daddr   dstore  rload         rdy | iw dw rr rw ramaddr ramstore iload         dload         ic dc
        tbl.push_back(mk(0,1,0,0,0, 32'h0, 32'h0,    32'h0,    32'h0,        0, 1,1,0,0, 32'h0,    32'h0,    32'h0,        32'h0,        0,0));
        tbl.push_back(mk(1,0,0,0,0, 32'h0, 32'h0,    32'h0,    32'h0,        0, 1,1,0,0, 32'h0,    32'h0,    32'h0,        32'h0,        0,0));
        // instruction read, ready on first access cycle
        tbl.push_back(mk(1,0,1,0,0, 32'h40,32'h0,    32'h0,    32'hDEADBEEF, 1, 1,1,0,0, 32'h0,    32'h0,    32'h0,        32'h0,        0,0));
        tbl.push_back(mk(1,0,1,0,0, 32'h40,32'h0,    32'h0,    32'hDEADBEEF, 1, 0,1,1,0, 32'h40,   32'h0,    32'hDEADBEEF, 32'h0,        0,0));
        tbl.push_back(mk(1,0,0,0,0, 32'h0, 32'h0,    32'h0,    32'hDEADBEEF, 0, 1,1,0,0, 32'h40,   32'h0,    32'h0,        32'h0,        1,0));
        // data write with three wait cycles
        tbl.push_back(mk(1,0,0,0,1, 32'h0, 32'h3100, 32'h1234, 32'hCAFE0001, 0, 1,1,0,0, 32'h40,   32'h0,    32'h0,        32'h0,        1,0));
        tbl.push_back(mk(1,0,0,0,1, 32'h0, 32'h3100, 32'h1234, 32'hCAFE0001, 0, 1,1,0,1, 32'h3100, 32'h1234, 32'h0,        32'h0,        1,0));
        tbl.push_back(mk(1,0,0,0,1, 32'h0, 32'h3100, 32'h1234, 32'hCAFE0001, 0, 1,1,0,1, 32'h3100, 32'h1234, 32'h0,        32'h0,        1,0));
        tbl.push_back(mk(1,0,0,0,1, 32'h0, 32'h3100, 32'h1234, 32'hCAFE0001, 0, 1,1,0,1, 32'h3100, 32'h1234, 32'h0,        32'h0,        1,0));
        tbl.push_back(mk(1,0,0,0,1, 32'h0, 32'h3100, 32'h1234, 32'hCAFE0001, 1, 1,0,0,1, 32'h3100, 32'h1234, 32'h0,        32'hCAFE0001, 1,0));
        tbl.push_back(mk(1,0,0,0,0, 32'h0, 32'h0,    32'h0,    32'hCAFE0001, 1, 1,1,0,0, 32'h3100, 32'h1234, 32'h0,        32'h0,        1,1));
        // simultaneous requests: data first, idle gap, then instruction
        tbl.push_back(mk(1,0,1,1,0, 32'h80,32'h100,  32'h0,    32'h11,       1, 1,1,0,0, 32'h3100, 32'h1234, 32'h0,        32'h0,        1,1));
        tbl.push_back(mk(1,0,1,1,0, 32'h80,32'h100,  32'h0,    32'h11,       1, 1,0,1,0, 32'h100,  32'h0,    32'h0,        32'h11,       1,1));
        tbl.push_back(mk(1,0,1,0,0, 32'h80,32'h100,  32'h0,    32'h11,       1, 1,1,0,0, 32'h100,  32'h0,    32'h0,        32'h0,        1,2));
        tbl.push_back(mk(1,0,1,0,0, 32'h80,32'h100,  32'h0,    32'h11,       1, 0,1,1,0, 32'h80,   32'h0,    32'h11,       32'h0,        1,2));
        tbl.push_back(mk(1,0,0,0,0, 32'h0, 32'h0,    32'h0,    32'h0,        0, 1,1,0,0, 32'h80,   32'h0,    32'h0,        32'h0,        2,2));
        // abort after two stalled cycles, then a fresh read
        tbl.push_back(mk(1,0,0,1,0, 32'h0, 32'h200,  32'h0,    32'h0,        0, 1,1,0,0, 32'h80,   32'h0,    32'h0,        32'h0,        2,2));
        tbl.push_back(mk(1,0,0,1,0, 32'h0, 32'h200,  32'h0,    32'h0,        0, 1,1,1,0, 32'h200,  32'h0,    32'h0,        32'h0,        2,2));
        tbl.push_back(mk(1,0,0,1,0, 32'h0, 32'h200,  32'h0,    32'h0,        0, 1,1,1,0, 32'h200,  32'h0,    32'h0,        32'h0,        2,2));
        tbl.push_back(mk(1,0,0,0,0, 32'h0, 32'h200,  32'h0,    32'h0,        0, 1,1,0,0, 32'h200,  32'h0,    32'h0,        32'h0,        2,2));
        tbl.push_back(mk(1,0,0,1,0, 32'h0, 32'h204,  32'h0,    32'h22,       1, 1,1,0,0, 32'h200,  32'h0,    32'h0,        32'h0,        2,2));
        tbl.push_back(mk(1,0,0,1,0, 32'h0, 32'h204,  32'h0,    32'h22,       1, 1,0,1,0, 32'h204,  32'h0,    32'h0,        32'h22,       2,2));
        tbl.push_back(mk(1,0,0,0,0, 32'h0, 32'h0,    32'h0,    32'h22,       0, 1,1,0,0, 32'h204,  32'h0,    32'h0,        32'h0,        2,3));
        // read+write together is a write
        tbl.push_back(mk(1,0,0,1,1, 32'h0, 32'h8,    32'h55,   32'h22,       0, 1,1,0,0, 32'h204,  32'h0,    32'h0,        32'h0,        2,3));
        tbl.push_back(mk(1,0,0,1,1, 32'h0, 32'h8,    32'h55,   32'h22,       1, 1,0,0,1, 32'h8,    32'h55,   32'h0,        32'h22,       2,3));
        tbl.push_back(mk(1,0,0,0,0, 32'h0, 32'h0,    32'h0,    32'h0,        0, 1,1,0,0, 32'h8,    32'h55,   32'h0,        32'h0,        2,4));
        // reset during a data access
        tbl.push_back(mk(1,0,0,1,0, 32'h0, 32'h300,  32'h0,    32'h0,        0, 1,1,0,0, 32'h8,    32'h55,   32'h0,        32'h0,        2,4));
        tbl.push_back(mk(1,0,0,1,0, 32'h0, 32'h300,  32'h0,    32'h0,        0, 1,1,1,0, 32'h300,  32'h0,    32'h0,        32'h0,        2,4));
        tbl.push_back(mk(1,1,0,1,0, 32'h0, 32'h300,  32'h0,    32'h0,        0, 1,1,1,0, 32'h300,  32'h0,    32'h0,        32'h0,        2,4));
        tbl.push_back(mk(1,0,0,1,0, 32'h0, 32'h300,  32'h0,    32'h0,        0, 1,1,0,0, 32'h0,    32'h0,    32'h0,        32'h0,        0,0));
        tbl.push_back(mk(1,0,0,0,0, 32'h0, 32'h0,    32'h0,    32'h0,        0, 1,1,0,0, 32'h300,  32'h0,    32'h0,        32'h0,        0,0));
        tbl.push_back(mk(1,0,0,0,0, 32'h0, 32'h0,    32'h0,    32'h0,        1, 1,1,0,0, 32'h300,  32'h0,    32'h0,        32'h0,        0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            rst = tbl[i].rst; iren = tbl[i].iren; dren = tbl[i].dren; dwen = tbl[i].dwen;
            rdy = tbl[i].rdy; iaddr = tbl[i].iaddr; daddr = tbl[i].daddr;
            dstore = tbl[i].dstore; rload = tbl[i].rload;
            @(negedge clk);
            if (tbl[i].chk) begin
                check("iwait",    i, {31'b0, iwait},  {31'b0, tbl[i].e_iw});
                check("dwait",    i, {31'b0, dwait},  {31'b0, tbl[i].e_dw});
                check("ramREN",   i, {31'b0, ramren}, {31'b0, tbl[i].e_rr});
                check("ramWEN",   i, {31'b0, ramwen}, {31'b0, tbl[i].e_rw});
                check("ramaddr",  i, ramaddr,  tbl[i].e_ra);
                check("ramstore", i, ramstore, tbl[i].e_rs);
                check("iload",    i, iload,    tbl[i].e_il);
                check("dload",    i, dload,    tbl[i].e_dl);
                check("icount",   i, icount,   tbl[i].e_ic);
                check("dcount",   i, dcount,   tbl[i].e_dc);
            end
        end

        // Narrow counter: five back-to-back data reads wrap 1,2,3,0,1.
        @(posedge clk); #1;
        s_rst = 1'b1;
        @(posedge clk); #1;
        s_rst = 1'b0;
        @(negedge clk);
        check("wrap_reset_dcount", 0, {30'b0, s_dcount}, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            s_dren = 1'b1; s_rdy = 1'b1;
            done = 1'b0;
            for (int c = 0; c < 8 && !done; c++) begin
                @(negedge clk);
                if (!s_dwait) done = 1'b1;
                else begin
                    @(posedge clk); #1;
                end
            end
            check("wrap_dwait_release", k, {31'b0, done}, 32'h1);
            check("wrap_dload", k, s_dload, 32'h0000_00A5);
            @(posedge clk); #1;
            s_dren = 1'b0;
            @(negedge clk);
            check("wrap_dcount", k, {30'b0, s_dcount}, {30'b0, exp_cnt[k]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
